// File: rtl/freqout_pkg.sv
// ---------------------------------------------------------------------------
// freqout_pkg
//
// Shared definitions for the frequency output generator:
//   - PERIOD_BITS_DEFAULT : default width of period values and counters
//   - MIN_PERIOD_DEFAULT  : smallest period (in clk cycles) that starts output
//   - state_e             : generator FSM states (idle, high phase, low phase)
// ---------------------------------------------------------------------------
package freqout_pkg;

  localparam int unsigned PERIOD_BITS_DEFAULT = 32;
  localparam int unsigned MIN_PERIOD_DEFAULT  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

endpackage : freqout_pkg

// File: rtl/freqout_phase_split.sv
// ---------------------------------------------------------------------------
// freqout_phase_split
//
// Purely combinational split of one output period P into a high-phase length
// H and a low-phase length L, with H + L = P.
//
// Build option FREQOUT_DUTY_EN:
//   undefined : H = floor(P/2), L = P - H (odd P puts the extra cycle in LOW)
//   defined   : H = clamp(duty, 1, P-1), L = P - H
//
// Ports:
//   period   in  PERIOD_BITS  requested period P (only meaningful for P >= 2)
//   duty     in  PERIOD_BITS  requested high-phase length (FREQOUT_DUTY_EN only)
//   high_len out PERIOD_BITS  H
//   low_len  out PERIOD_BITS  L
//
// For P < 2 the outputs are don't-care: the caller never starts such a period.
// ---------------------------------------------------------------------------
module freqout_phase_split #(
  parameter int unsigned PERIOD_BITS = 32
) (
  input  logic [PERIOD_BITS-1:0] period,
`ifdef FREQOUT_DUTY_EN
  input  logic [PERIOD_BITS-1:0] duty,
`endif
  output logic [PERIOD_BITS-1:0] high_len,
  output logic [PERIOD_BITS-1:0] low_len
);

  localparam logic [PERIOD_BITS-1:0] ONE = {{(PERIOD_BITS-1){1'b0}}, 1'b1};

  always_comb begin
`ifdef FREQOUT_DUTY_EN
    // Clamp so both phases are at least one cycle long.
    if (duty == '0) begin
      high_len = ONE;
    end else if (duty >= period) begin
      high_len = period - ONE;
    end else begin
      high_len = duty;
    end
`else
    high_len = period >> 1;
`endif
    // H <= P always holds, so this subtraction cannot wrap, even for the
    // all-ones period.
    low_len = period - high_len;
  end

endmodule : freqout_phase_split

// File: rtl/freqout_gen.sv
// ---------------------------------------------------------------------------
// freqout_gen
//
// Frequency output generator. Produces a square wave on freq_out whose period
// is given in clk cycles, the same unit the frequency-input measurement block
// reports, so a measured value can be looped straight back in.
//
// A new period/duty is only taken at a period boundary (from idle, or on the
// last low cycle of the running period), so the output never carries runt or
// truncated pulses. Dropping enable lets the current period finish.
//
// Build option: define FREQOUT_DUTY_EN to add the duty input (programmable
// high-phase length). Without it the output runs at 50 % duty, with the extra
// cycle of an odd period placed in the low phase.
//
// Parameters:
//   PERIOD_BITS  width of period, duty, cur_period and internal counters
//   MIN_PERIOD   smallest period that runs (must be >= 2); smaller means stop
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   enable       in   run request
//   period       in   requested period in clk cycles
//   duty         in   requested high-phase length (FREQOUT_DUTY_EN only)
//   freq_out     out  generated waveform (registered)
//   active       out  high while a period is being generated
//   cur_period   out  period being generated, 0 when idle
//   period_done  out  high during the last cycle of each completed period
// ---------------------------------------------------------------------------
module freqout_gen
  import freqout_pkg::*;
#(
  parameter int unsigned PERIOD_BITS = PERIOD_BITS_DEFAULT,
  parameter int unsigned MIN_PERIOD  = MIN_PERIOD_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [PERIOD_BITS-1:0] period,
`ifdef FREQOUT_DUTY_EN
  input  logic [PERIOD_BITS-1:0] duty,
`endif
  output logic                   freq_out,
  output logic                   active,
  output logic [PERIOD_BITS-1:0] cur_period,
  output logic                   period_done
);

  localparam logic [PERIOD_BITS-1:0] ONE   = {{(PERIOD_BITS-1){1'b0}}, 1'b1};
  localparam logic [PERIOD_BITS-1:0] MIN_P = PERIOD_BITS'(MIN_PERIOD);

  // -------------------------------------------------------------------------
  // Phase split of the requested period (only used at a period boundary)
  // -------------------------------------------------------------------------
  logic [PERIOD_BITS-1:0] req_high_len;
  logic [PERIOD_BITS-1:0] req_low_len;

  freqout_phase_split #(
    .PERIOD_BITS (PERIOD_BITS)
  ) u_phase_split (
    .period   (period),
`ifdef FREQOUT_DUTY_EN
    .duty     (duty),
`endif
    .high_len (req_high_len),
    .low_len  (req_low_len)
  );

  logic req_valid;
  assign req_valid = enable && (period >= MIN_P);

  // -------------------------------------------------------------------------
  // State
  //   cnt_q      cycles left in the current phase, including this one
  //   low_len_q  low-phase length of the running period, kept so the phase
  //              split only ever looks at the live inputs at a boundary
  // -------------------------------------------------------------------------
  state_e                 state_q,       state_d;
  logic [PERIOD_BITS-1:0] cnt_q,         cnt_d;
  logic [PERIOD_BITS-1:0] low_len_q,     low_len_d;
  logic [PERIOD_BITS-1:0] cur_period_q,  cur_period_d;
  logic                   freq_out_q,    freq_out_d;
  logic                   active_q,      active_d;
  logic                   period_done_q, period_done_d;
  logic                   start_period;

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves a
    // signal unassigned; an unassigned path in always_comb infers a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    low_len_d    = low_len_q;
    cur_period_d = cur_period_q;
    start_period = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        start_period = req_valid;
      end

      ST_HIGH: begin
        if (cnt_q == ONE) begin
          state_d = ST_LOW;
          cnt_d   = low_len_q;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end

      ST_LOW: begin
        if (cnt_q == ONE) begin
          // Period boundary: the only place besides idle where the inputs
          // are looked at. A valid request chains on with no gap.
          if (req_valid) begin
            start_period = 1'b1;
          end else begin
            state_d      = ST_IDLE;
            cnt_d        = '0;
            low_len_d    = '0;
            cur_period_d = '0;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end

      default: begin
        state_d      = ST_IDLE;
        cnt_d        = '0;
        low_len_d    = '0;
        cur_period_d = '0;
      end
    endcase

    if (start_period) begin
      state_d      = ST_HIGH;
      cnt_d        = req_high_len;
      low_len_d    = req_low_len;
      cur_period_d = period;
    end

    // Outputs are decoded from the next state and registered, so they line
    // up with the state they describe and have no combinational path out.
    freq_out_d    = (state_d == ST_HIGH);
    active_d      = (state_d != ST_IDLE);
    period_done_d = (state_d == ST_LOW) && (cnt_d == ONE);
  end

  // NOTE: sequential state uses non-blocking assignments only; all next-state
  // arithmetic lives in the always_comb above with blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      low_len_q     <= '0;
      cur_period_q  <= '0;
      freq_out_q    <= 1'b0;
      active_q      <= 1'b0;
      period_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      low_len_q     <= low_len_d;
      cur_period_q  <= cur_period_d;
      freq_out_q    <= freq_out_d;
      active_q      <= active_d;
      period_done_q <= period_done_d;
    end
  end

  assign freq_out    = freq_out_q;
  assign active      = active_q;
  assign cur_period  = cur_period_q;
  assign period_done = period_done_q;

endmodule : freqout_gen

// File: doc/freqout_gen.md
# freqout_gen

Frequency output generator: produces a square wave on `freq_out` whose period is set in system-clock cycles. It is the transmit-side counterpart of the frequency-input measurement plugin. Both use the same "period in `clk` cycles" unit, so a measured value can be looped back unchanged. New period values are applied only on period boundaries, so the output never carries runt or truncated pulses.

## Interface
- `PERIOD_BITS`, 32: width of `period` and of the internal counters.
- `MIN_PERIOD`, 2: smallest accepted period. Must be at least 2.
- `clk`  in  1: system clock, single clock domain.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `enable`  in  1: run request.
- `period`  in  PERIOD_BITS: requested output period in `clk` cycles. Values below `MIN_PERIOD` mean stop.
- `freq_out`  out  1: generated waveform, registered.
- `active`  out  1: high while a period is being generated.
- `cur_period`  out  PERIOD_BITS: period currently being generated; 0 when idle.
- `period_done`  out  1: one-cycle pulse on the last cycle of each completed period.

## Operation
- FSM states: IDLE, HIGH, LOW.
- A period is valid when `enable` is 1 and `period >= MIN_PERIOD`.
- IDLE:
  - If a valid period is sampled, latch `period` into `cur_period`.
  - Load the high-phase length into the counter and go to HIGH.
  - Otherwise stay in IDLE.
- Phase split (default build):
  - H = floor(P/2), L = P − H.
  - Examples: P=5 gives H=2, L=3; P=2 gives H=1, L=1.
- HIGH: count H cycles, then load L and go to LOW.
- LOW: count L cycles. On the last LOW cycle, pulse `period_done` and re-evaluate the inputs:
  - Valid: latch the new `period` and go to HIGH. The next period starts on the following cycle with no gap.
  - Not valid: go to IDLE, clear `cur_period`, set `active` to 0.
- The `period` input is sampled only in IDLE and on the last LOW cycle. Changes at any other time are ignored until that boundary.
- Deasserting `enable` mid-period does not cut the waveform short. The current period completes in full, then the block goes to IDLE.
- `freq_out` = 1 exactly in the HIGH state. It is driven from a register, with no combinational path to the output.
- Counters are PERIOD_BITS wide. `period` = 2^PERIOD_BITS − 1 is legal, and nothing overflows.
- Reset: when `rst_n` falls, the following are set immediately, whatever the current state:
  - FSM to IDLE
  - `freq_out` = 0, `active` = 0, `cur_period` = 0, `period_done` = 0
  - counters = 0

## Timing
- Start latency:
  - A valid request is sampled at clock edge n.
  - `freq_out` and `active` go to 1 from edge n+1.
  - `cur_period` is updated at edge n+1.
- Steady state: each period is exactly P cycles; `freq_out` is high for H cycles, then low for L cycles.
- `period_done` is high during the final LOW cycle of each period.
- Period change: the new value takes effect at the first HIGH cycle after the next `period_done`.
- Stop: `freq_out` stays 0 from the cycle after the final `period_done`.
- Release of `rst_n`: the first valid request can be sampled at the first clock edge after release.

## Configuration
- Macro: `FREQOUT_DUTY_EN`.
- Defined:
  - Adds input `duty`  in  PERIOD_BITS: high-phase length in cycles.
  - `duty` is sampled together with `period`.
  - H = clamp(duty, 1, P−1); L = P − H.
  - `duty` = 0 is treated as 1; `duty >= P` is treated as P−1.
- Undefined:
  - No `duty` port.
  - H = floor(P/2), i.e. 50 % duty with the extra cycle in LOW for odd P.

## Structure
- Package `freqout_pkg` holds:
  - the FSM state enum (IDLE, HIGH, LOW)
  - the `MIN_PERIOD` default
- Sub-module `freqout_phase_split`: purely combinational, P (and `duty`) → H, L, including the clamping rules. The top level holds the FSM, counters and output registers.

## Test plan
1. Reset and start-up:
   - Stimulus: `rst_n` low, then high; `enable`=1, `period`=10 sampled at edge n.
   - Required: all outputs 0 during reset. `freq_out` high from edge n+1, as 5 high / 5 low cycles, repeating. `period_done` pulses every 10 cycles.
2. Odd period and minimum:
   - Stimulus: P=5, then P=2, then P=1.
   - Required: 2 high / 3 low; then 1 high / 1 low; then a transition to IDLE with `active`=0 after the current period completes.
3. Mid-period change:
   - Stimulus: P=8 running; switch to P=4 on cycle 2 of HIGH.
   - Required: the current 8-cycle period completes unchanged. The next period is 2 high / 2 low, with no gap and no runt pulse.
4. Disable mid-period:
   - Stimulus: P=6; deassert `enable` on cycle 1 of LOW.
   - Required: LOW runs its full 3 cycles. `period_done` pulses, then IDLE. `freq_out` stays 0 and `cur_period` = 0.
5. Asynchronous reset mid-HIGH:
   - Stimulus: pull `rst_n` low between clock edges while `freq_out`=1.
   - Required: `freq_out`, `active` and `cur_period` are 0 immediately, without waiting for a clock edge.
6. `FREQOUT_DUTY_EN` build:
   - Stimulus: P=10 with `duty` = 3, then 0, then 12.
   - Required: 3 high / 7 low; then 1 high / 9 low; then 9 high / 1 low.
